ecc_ff_arith: RTL and testbench



---
 rtl/ecc_ff_pkg.sv | 23 ++
 rtl/ecc_ff_digit_mul.sv | 24 ++
 rtl/ecc_ff_arith.sv | 156 +++++++++++++++
 tb/tb_ecc_ff_arith.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_ff_pkg.sv
// Shared constants, op encodings and state type for the GF(2^M) arithmetic unit.
package ecc_ff_pkg;

  localparam int unsigned M_DEFAULT = 163;
  // x^163 + x^7 + x^6 + x^3 + 1, with the x^M term left implicit
  localparam logic [162:0] POLY_B163 = 163'hC9;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_SQR = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic int unsigned num_digits(input int unsigned m, input int unsigned d);
    return (m + d - 1) / d;
  endfunction

endpackage

// File: rtl/ecc_ff_digit_mul.sv
// One digit step of the MSB-first digit-serial multiplier:
// acc_o = acc_i * x^D + a_i * digit_i, reduced mod f.
module ecc_ff_digit_mul
  import ecc_ff_pkg::*;
#(
  parameter int unsigned  M    = M_DEFAULT,
  parameter int unsigned  D    = 8,
  parameter logic [M-1:0] POLY = M'(POLY_B163)
) (
  input  logic [M-1:0] acc_i,
  input  logic [M-1:0] a_i,
  input  logic [D-1:0] digit_i,
  output logic [M-1:0] acc_o
);

  // Horner over the digit bits: each step multiplies by x, reduces, then adds a_i if set.
  always_comb begin
    acc_o = acc_i;
    for (int i = int'(D) - 1; i >= 0; i--) begin
      acc_o = {acc_o[M-2:0], 1'b0} ^ (acc_o[M-1] ? POLY : '0) ^ (digit_i[i] ? a_i : '0);
    end
  end

endmodule

// File: rtl/ecc_ff_arith.sv
// Multi-op GF(2^M) unit: ADD, digit-serial MUL, SQR, with valid/ready on both sides.
// Define ECC_FF_FAST_SQR_EN to compute SQR in a single cycle with a combinational squarer.
module ecc_ff_arith
  import ecc_ff_pkg::*;
#(
  parameter int unsigned  M    = M_DEFAULT,
  parameter int unsigned  D    = 8,
  parameter logic [M-1:0] POLY = M'(POLY_B163)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] q
);

  localparam int unsigned N    = num_digits(M, D);
  localparam int unsigned NB   = N * D;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

`ifdef ECC_FF_FAST_SQR_EN
  localparam bit FastSqr = 1'b1;
`else
  localparam bit FastSqr = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [M-1:0]      acc_q, acc_d;
  logic [M-1:0]      a_q, a_d;
  logic [NB-1:0]     b_q, b_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [M-1:0]      q_q, q_d;
  logic [M-1:0]      acc_next;
  logic [M-1:0]      sqr_res;

  ecc_ff_digit_mul #(
    .M   (M),
    .D   (D),
    .POLY(POLY)
  ) u_digit_mul (
    .acc_i  (acc_q),
    .a_i    (a_q),
    .digit_i(b_q[NB-1 -: D]),
    .acc_o  (acc_next)
  );

  if (FastSqr) begin : g_fast_sqr
    localparam logic [2*M-2:0] PolyExt = {{(M-1){1'b0}}, POLY};
    logic [2*M-2:0] sq_v;
    // Interleave zeros, then fold the upper half down from the top bit.
    always_comb begin
      sq_v = '0;
      for (int i = 0; i < int'(M); i++) begin
        sq_v[2*i] = a[i];
      end
      for (int i = 2 * int'(M) - 2; i >= int'(M); i--) begin
        if (sq_v[i]) begin
          sq_v[i] = 1'b0;
          sq_v    = sq_v ^ (PolyExt << (i - int'(M)));
        end
      end
      sqr_res = sq_v[M-1:0];
    end
  end else begin : g_no_fast_sqr
    assign sqr_res = '0;
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          unique case (op)
            OP_ADD: begin
              q_d     = a ^ b;
              state_d = StDone;
            end
            OP_RSV: begin
              q_d     = '0;
              state_d = StDone;
            end
            OP_MUL: begin
              a_d     = a;
              b_d     = NB'(b);
              acc_d   = '0;
              cnt_d   = '0;
              state_d = StRun;
            end
            OP_SQR: begin
              if (FastSqr) begin
                q_d     = sqr_res;
                state_d = StDone;
              end else begin
                a_d     = a;
                b_d     = NB'(a);
                acc_d   = '0;
                cnt_d   = '0;
                state_d = StRun;
              end
            end
          endcase
        end
      end
      StRun: begin
        acc_d = acc_next;
        b_d   = b_q << D;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 1)) begin
          q_d     = acc_next;
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_ecc_ff_arith.sv
// Scoreboard bench: three instances (D = 1, 8, 163) share one stimulus stream; a monitor per
// instance pops expectations when out_valid rises and checks result, latency and handshake.
module tb_ecc_ff_arith;
  import ecc_ff_pkg::*;

  localparam int unsigned M  = 163;
  localparam int          NI = 3;
`ifdef ECC_FF_FAST_SQR_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam logic [M-1:0] TB_POLY = 163'hC9;
  localparam logic [M-1:0] K = 163'h5_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F0F_1E1E;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [1:0]   op = 2'b00;
  logic [M-1:0] a = '0;
  logic [M-1:0] b = '0;
  logic         in_ready_w [NI];
  logic         out_valid_w[NI];
  logic [M-1:0] q_w        [NI];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd[NI];
  logic ordy_e = 1'b1;

  typedef struct {
    logic [M-1:0] q;
    logic [1:0]   op;
    int           acc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) ordy_e <= out_ready;

  function automatic void chk(input string nm, input int d, input logic [M-1:0] act,
                              input logic [M-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s D=%0d cyc=%0d got=%h want=%h", nm, d, cyc, act, expv);
    end
  endfunction

  function automatic logic [M-1:0] xt(input logic [M-1:0] v);
    return {v[M-2:0], 1'b0} ^ (v[M-1] ? TB_POLY : '0);
  endfunction

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [M-1:0] r = '0;
    for (int i = int'(M) - 1; i >= 0; i--) begin
      r = xt(r);
      if (y[i]) r = r ^ x;
    end
    return r;
  endfunction

  function automatic logic [M-1:0] model(input logic [1:0] o, input logic [M-1:0] x,
                                         input logic [M-1:0] y);
    case (o)
      OP_ADD:  return x ^ y;
      OP_MUL:  return gf_mul(x, y);
      OP_SQR:  return gf_mul(x, x);
      default: return '0;
    endcase
  endfunction

  // Acceptance edge counts as the first edge.
  function automatic int exp_lat(input int d, input logic [1:0] o);
    int n = (int'(M) + d - 1) / d;
    if (o == OP_MUL) return n + 1;
    if (o == OP_SQR) return FAST ? 1 : n + 1;
    return 1;
  endfunction

  function automatic logic [M-1:0] rnd();
    logic [191:0] t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[M-1:0];
  endfunction

  genvar k;
  for (k = 0; k < NI; k++) begin : g_dut
    localparam int DK = (k == 0) ? 1 : (k == 1) ? 8 : 163;

    ecc_ff_arith #(
      .M(M),
      .D(DK)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready_w[k]),
      .op       (op),
      .a        (a),
      .b        (b),
      .out_valid(out_valid_w[k]),
      .out_ready(out_ready),
      .q        (q_w[k])
    );

    initial begin : mon
      logic         prev_ov;
      logic [M-1:0] hold;
      exp_t         e;
      prev_ov = 1'b0;
      hold    = '0;
      rd[k]   = 0;
      forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
          chk("rst_out_valid", DK, M'(out_valid_w[k]), '0);
          chk("rst_in_ready", DK, M'(in_ready_w[k]), M'(1));
          chk("rst_q", DK, q_w[k], '0);
          prev_ov = 1'b0;
          rd[k]   = 0;
        end else begin
          if (prev_ov && ordy_e) begin
            chk("drop_out_valid", DK, M'(out_valid_w[k]), '0);
            chk("drop_in_ready", DK, M'(in_ready_w[k]), M'(1));
          end else if (prev_ov) begin
            chk("hold_out_valid", DK, M'(out_valid_w[k]), M'(1));
            chk("hold_q", DK, q_w[k], hold);
            chk("hold_in_ready", DK, M'(in_ready_w[k]), '0);
          end else if (out_valid_w[k]) begin
            if (rd[k] >= exp_q.size()) begin
              chk("spurious_out_valid", DK, M'(out_valid_w[k]), '0);
            end else begin
              e = exp_q[rd[k]];
              rd[k]++;
              hold = e.q;
              chk("result_q", DK, q_w[k], e.q);
              chk("latency", DK, M'(cyc - e.acc + 1), M'(exp_lat(DK, e.op)));
            end
          end else if (rd[k] < exp_q.size() && cyc >= exp_q[rd[k]].acc) begin
            chk("busy_in_ready", DK, M'(in_ready_w[k]), '0);
          end
          prev_ov = out_valid_w[k];
        end
      end
    end
  end

  function automatic bit all_idle();
    bit r = 1'b1;
    for (int i = 0; i < NI; i++) r = r & in_ready_w[i] & ~out_valid_w[i];
    return r;
  endfunction

  function automatic bit all_ov();
    bit r = 1'b1;
    for (int i = 0; i < NI; i++) r = r & out_valid_w[i];
    return r;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!all_idle() && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!all_idle()) chk("idle_timeout", 0, M'(all_idle()), M'(1));
  endtask

  task automatic issue(input logic [1:0] o, input logic [M-1:0] av, input logic [M-1:0] bv,
                       input logic [M-1:0] expq);
    wait_idle();
    exp_q.push_back('{q: expq, op: o, acc: cyc + 1});
    op       = o;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a        = '1;
    b        = '1;
    op       = OP_RSV;
  endtask

  initial begin
    logic [M-1:0] one;
    logic [M-1:0] ra, rb;
    logic [1:0]   ro;
    int           n;
    one = M'(1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(OP_ADD, M'(1), M'(3), M'(2));
    issue(OP_MUL, M'(2), one << 162, M'(163'hC9));
    issue(OP_SQR, one << 82, '0, M'(163'h192));
    issue(OP_SQR, one << 81, '0, one << 162);
    issue(OP_RSV, M'(5), M'(6), '0);

    // Backpressure: hold out_ready low for 5 cycles once every instance has a result.
    wait_idle();
    out_ready = 1'b0;
    issue(OP_MUL, M'(1), K, K);
    n = 0;
    while (!all_ov() && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!all_ov()) chk("ov_timeout", 0, M'(all_ov()), M'(1));
    repeat (5) @(negedge clk);
    out_ready = 1'b1;

    // Reset on the 10th RUN edge of a MUL.
    issue(OP_MUL, K, K, gf_mul(K, K));
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_ADD, M'(5), M'(6), M'(3));

    for (int i = 0; i < 56; i++) begin
      ra = rnd();
      rb = rnd();
      ro = 2'($urandom_range(0, 3));
      issue(ro, ra, rb, model(ro, ra, rb));
    end

    wait_idle();
    @(negedge clk);
    for (int i = 0; i < NI; i++) chk("drained", i, M'(rd[i]), M'(exp_q.size()));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
